// File: rtl/step_key_ctrl.sv
// step_key_ctrl: two-flop synchroniser, debounce FSM and step counter for
// manual single-stepping of the CPU. Emits one registered step_pulse per
// accepted press and counts accepted steps.
// Optional auto-repeat while held: define STEP_KEY_AUTOREPEAT_EN.
module step_key_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20,
    parameter logic        KEY_POL         = 1'b1,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        key_in,
    output logic        step_pulse,
    output logic        key_level,
    output logic [15:0] step_count
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Reject parameter sets the debounce/repeat logic cannot honour.
    if ((DEBOUNCE_CYCLES < 2) || (CNT_W < 1) || (CNT_W > 32) ||
        (64'(DEBOUNCE_CYCLES) >= (64'd1 << CNT_W)) ||
        (REPEAT_DELAY == 0) || (REPEAT_PERIOD == 0)) begin : g_bad_params
        $error("step_key_ctrl: illegal parameter combination");
    end

    logic             sync1_q;
    logic             sync2_q;
    logic             key_sync;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pulse_d;
    logic             level_d;
    logic [15:0]      count_d;
    logic             rep_fire;

    // Two-flop synchroniser, parked at the inactive key level in reset.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            sync1_q <= ~KEY_POL;
            sync2_q <= ~KEY_POL;
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
        end
    end

    assign key_sync = (sync2_q == KEY_POL);

`ifdef STEP_KEY_AUTOREPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

    logic [REP_W-1:0] rep_cnt_q;
    logic [REP_W-1:0] rep_cnt_d;
    logic             rep_first_q;
    logic             rep_first_d;

    // A repeat fires on a HELD edge that keeps the key down once the
    // current interval (first delay, then period) has elapsed.
    assign rep_fire = (state_q == HELD) && key_sync &&
                      (rep_cnt_q == (rep_first_q ? REP_DELAY_LAST : REP_PERIOD_LAST));

    // Repeat counter: cleared on entry to HELD, counts while HELD,
    // frozen in every other state.
    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
        if (state_d == HELD) begin
            if (state_q != HELD) begin
                rep_cnt_d   = '0;
                rep_first_d = 1'b1;
            end else if (rep_fire) begin
                rep_cnt_d   = '0;
                rep_first_d = 1'b0;
            end else begin
                rep_cnt_d = rep_cnt_q + 1'b1;
            end
        end
    end

    // Repeat counter registers.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    // Debounce FSM next-state and registered-output values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        level_d = key_level;
        count_d = step_count;
        unique case (state_q)
            IDLE: begin
                if (key_sync) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            PRESS_WAIT: begin
                if (!key_sync) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                    level_d = 1'b1;
                    count_d = step_count + 16'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!key_sync) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_W'(1);
                end else if (rep_fire) begin
                    pulse_d = 1'b1;
                    count_d = step_count + 16'd1;
                end
            end
            RELEASE_WAIT: begin
                if (key_sync) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state and debounce counter registers.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered outputs; step_count is reloaded every cycle from count_d.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            step_pulse <= 1'b0;
            key_level  <= 1'b0;
            step_count <= '0;
        end else begin
            step_pulse <= pulse_d;
            key_level  <= level_d;
            step_count <= count_d;
        end
    end

endmodule

// File: tb/tb_step_key_ctrl.sv
// Testbench for step_key_ctrl: segment table, hand-written corner
// sequences and random key activity against a run-length reference model.
module tb_step_key_ctrl;

    localparam int unsigned DC = 4;
    localparam int unsigned RD = 20;
    localparam int unsigned RP = 8;
`ifdef STEP_KEY_AUTOREPEAT_EN
    localparam int unsigned AR = 1;
`else
    localparam int unsigned AR = 0;
`endif

    logic        clk = 1'b0;
    logic        RST;
    logic        key_in;
    logic        step_pulse;
    logic        key_level;
    logic [15:0] step_count;

    always #5 clk = ~clk;

    step_key_ctrl #(
        .DEBOUNCE_CYCLES(DC),
        .CNT_W          (20),
        .KEY_POL        (1'b1),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk       (clk),
        .RST       (RST),
        .key_in    (key_in),
        .step_pulse(step_pulse),
        .key_level (key_level),
        .step_count(step_count)
    );

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    // Reference model: key samples reach the debouncer two edges late; the
    // debounced level flips once DC consecutive samples disagree with it.
    logic        mq[$];
    logic        m_level;
    logic        m_prev;
    logic        m_pulse;
    int unsigned m_run;
    int unsigned m_rep;
    logic [15:0] m_count;
    logic        prev_pulse;

    typedef struct {
        logic        key;
        int unsigned cycles;
        int unsigned pulses;
        logic        level;
        logic [15:0] count;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mq.push_back(1'b0);
        mq.push_back(1'b0);
        m_level    = 1'b0;
        m_prev     = 1'b0;
        m_pulse    = 1'b0;
        m_run      = 0;
        m_rep      = 0;
        m_count    = '0;
        prev_pulse = 1'b0;
    endtask

    task automatic model_edge(input logic k);
        logic s;
        s = mq.pop_front();
        mq.push_back(k);
        m_pulse = 1'b0;
`ifdef STEP_KEY_AUTOREPEAT_EN
        if (m_level && m_prev && s) begin
            m_rep++;
            if (m_rep == RD || (m_rep > RD && ((m_rep - RD) % RP) == 0)) begin
                m_pulse = 1'b1;
                m_count = m_count + 16'd1;
            end
        end else begin
            m_rep = 0;
        end
`endif
        if (s != m_level) begin
            m_run++;
            if (m_run == DC) begin
                m_level = s;
                m_run   = 0;
                if (s) begin
                    m_pulse = 1'b1;
                    m_count = m_count + 16'd1;
                end
            end
        end else begin
            m_run = 0;
        end
        m_prev = s;
    endtask

    task automatic step(input logic k);
        key_in = k;
        @(posedge clk);
        model_edge(k);
        #1;
        check("pulse", 32'(step_pulse), 32'(m_pulse));
        check("level", 32'(key_level), 32'(m_level));
        check("count", 32'(step_count), 32'(m_count));
        check("no_back_to_back", 32'(step_pulse & prev_pulse), 32'd0);
        prev_pulse = step_pulse;
    endtask

    task automatic do_reset();
        RST = 1'b0;
        #1;
        check("rst_pulse", 32'(step_pulse), 32'd0);
        check("rst_level", 32'(key_level), 32'd0);
        check("rst_count", 32'(step_count), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        RST = 1'b1;
        model_reset();
    endtask

    initial begin
        int unsigned seen;
        int unsigned cyc;
        logic        lvl;
        int unsigned len;

        RST    = 1'b1;
        key_in = 1'b0;
        model_reset();
        #2;
        do_reset();

        // Segment table: idle, glitches, clean press, bouncy release, press.
        tbl.push_back('{1'b0, 50, 0, 1'b0, 16'd0});
        for (int i = 0; i < 5; i++) begin
            tbl.push_back('{1'b1, 2, 0, 1'b0, 16'd0});
            tbl.push_back('{1'b0, 4, 0, 1'b0, 16'd0});
        end
        tbl.push_back('{1'b1, 30, 1 + AR, 1'b1, 16'(1 + AR)});
        for (int i = 0; i < 6; i++)
            tbl.push_back('{logic'(i % 2), 1, 0, 1'b1, 16'(1 + AR)});
        tbl.push_back('{1'b0, 10, 0, 1'b0, 16'(1 + AR)});
        tbl.push_back('{1'b1, 10, 1, 1'b1, 16'(2 + AR)});
        tbl.push_back('{1'b0, 10, 0, 1'b0, 16'(2 + AR)});

        foreach (tbl[r]) begin
            seen = 0;
            for (int unsigned c = 0; c < tbl[r].cycles; c++) begin
                step(tbl[r].key);
                if (step_pulse) seen++;
            end
            check($sformatf("tbl%0d_pulses", r), seen, tbl[r].pulses);
            check($sformatf("tbl%0d_level", r), 32'(key_level), 32'(tbl[r].level));
            check($sformatf("tbl%0d_count", r), 32'(step_count), 32'(tbl[r].count));
        end

        // Press latency: pulse only after the sixth edge; release after four low samples.
        for (int i = 0; i < 8; i++) begin
            step(1'b1);
            check("latency_pulse", 32'(step_pulse), 32'(i == 5));
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0);
            check("release_level", 32'(key_level), 32'(i < 5));
        end

        // Reset while debouncing a press with the counter at 3.
        for (int i = 0; i < 5; i++) step(1'b1);
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1);
            check("post_reset_pulse", 32'(step_pulse), 32'(i == 5));
        end
        for (int i = 0; i < 8; i++) step(1'b0);

        // Counter wrap from 0xFFFF.
        force dut.step_count = 16'hFFFF;
        m_count = 16'hFFFF;
        step(1'b0);
        step(1'b0);
        release dut.step_count;
        #1;
        check("wrap_preload", 32'(step_count), 32'h0000_FFFF);
        for (int i = 0; i < 8; i++) begin
            step(1'b1);
            if (i == 5) begin
                check("wrap_pulse", 32'(step_pulse), 32'd1);
                check("wrap_count", 32'(step_count), 32'd0);
            end
        end
        for (int i = 0; i < 8; i++) step(1'b0);

        // Random key activity in segments of 1..8 cycles.
        cyc = 0;
        while (cyc < 3000) begin
            lvl = logic'($urandom_range(0, 1));
            len = $urandom_range(1, 8);
            for (int unsigned c = 0; c < len; c++) step(lvl);
            cyc += len;
        end
        for (int i = 0; i < 8; i++) step(1'b0);

`ifdef STEP_KEY_AUTOREPEAT_EN
        // Auto-repeat: hold 60 cycles past acceptance.
        do_reset();
        for (int i = 0; i < 65; i++) begin
            step(1'b1);
            check("repeat_pulse", 32'(step_pulse),
                  32'(i == 5 || (i >= 25 && ((i - 25) % 8) == 0)));
        end
        check("repeat_count", 32'(step_count), 32'd6);
        for (int i = 0; i < 8; i++) step(1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
